// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: PC-side handshake, instruction-memory read port and IF/ID outputs.
// The fetch unit is the slave; the PC/memory/decode environment is the master.
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INST_W = 8
);
  logic [ADDR_W-1:0] pc_addr;
  logic              jump_flag;
  logic              stall_in;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic              fetch_err;

  modport slave (
    input  pc_addr, jump_flag, stall_in, mem_ack, mem_rdata,
    output busy, mem_req, mem_addr, inst_out, inst_valid, fetch_err
  );

  modport master (
    output pc_addr, jump_flag, stall_in, mem_ack, mem_rdata,
    input  busy, mem_req, mem_addr, inst_out, inst_valid, fetch_err
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one req/ack memory read per PC value, result into IF/ID, wrong-path squash on jump.
// Optional FETCH_TIMEOUT_EN adds a WAIT watchdog with a sticky fetch_err and same-address retry.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INST_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  inst_fetch_unit_if.slave bus
);

  // The watchdog counter is 4 bits wide.
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic              advance;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] buf_q;
  logic              valid_q;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       err_q;
  logic       timeout;
`endif

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    timeout = 1'b0;
`endif
    unique case (state_q)
      StIdle: state_d = StWait;
      StWait: begin
        // An ack in the timeout cycle still completes normally.
        if (bus.mem_ack) begin
          advance = ~bus.stall_in;
          state_d = bus.stall_in ? StHold : StIdle;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == 4'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      StHold: begin
        if (!bus.stall_in) begin
          advance = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      inst_q     <= '0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Latch the PC only in IDLE so the address is stable for the whole request.
      if (state_q == StIdle) mem_addr_q <= bus.pc_addr;
      if (state_q == StWait && bus.mem_ack && bus.stall_in) buf_q <= bus.mem_rdata;
      if (advance) begin
        inst_q  <= (state_q == StHold) ? buf_q : bus.mem_rdata;
        valid_q <= ~bus.jump_flag;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIdle)                     cnt_q <= '0;
      else if (state_q == StWait && !bus.mem_ack) cnt_q <= cnt_q + 4'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.busy       = ~advance;
  assign bus.mem_req    = (state_q == StWait);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_out   = inst_q;
  assign bus.inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: PC model, table-driven memory responder, hand-derived checks.
// Define FETCH_TIMEOUT_EN on both bench and RTL to exercise the watchdog sequence.
module tb_inst_fetch_unit;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned INST_W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  inst_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  inst_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC model: advances on any edge where busy is low.
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] jump_addr;
  always @(posedge clk or posedge rst) begin
    if (rst)            pc <= '0;
    else if (!bus.busy) pc <= bus.jump_flag ? jump_addr : pc + 4'd1;
  end
  assign bus.pc_addr = pc;

  // Memory: acks after delay_tab[addr] extra request cycles with data mem_tab[addr].
  logic [INST_W-1:0] mem_tab   [16];
  int                delay_tab [16];
  int                req_cycles;
  logic              model_ack;
  logic [INST_W-1:0] model_rdata;
  logic              stray;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      model_ack   <= (req_cycles == delay_tab[bus.mem_addr]);
      model_rdata <= mem_tab[bus.mem_addr];
      req_cycles  <= req_cycles + 1;
    end else begin
      model_ack  <= 1'b0;
      req_cycles <= 0;
    end
  end
  assign bus.mem_ack   = model_ack | stray;
  assign bus.mem_rdata = stray ? 8'hEE : model_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    step();
    while (!bus.mem_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.mem_req) check(tag, bus.mem_req, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    stray = 1'b0;
    bus.stall_in = 1'b0;
    bus.jump_flag = 1'b0;
    jump_addr = '0;
    req_cycles = 0;
    model_ack = 1'b0;
    model_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem_tab[i] = '0;
      delay_tab[i] = 0;
    end
    mem_tab[0] = 8'hA5; mem_tab[1] = 8'h5A; mem_tab[2] = 8'h3C;
    mem_tab[3] = 8'h77; mem_tab[4] = 8'h11; mem_tab[9] = 8'hC3;
    delay_tab[2] = 5; delay_tab[4] = 2; delay_tab[10] = 3;

    // Reset state
    step(); step();
    check("rst busy", bus.busy, 1);
    check("rst mem_req", bus.mem_req, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst inst_out", bus.inst_out, 0);
    check("rst inst_valid", bus.inst_valid, 0);
    check("rst fetch_err", bus.fetch_err, 0);
    rst = 1'b0;

    // Single-cycle ack at addr 0, then addr 1
    wait_req("t1 req");
    check("t1 mem_addr", bus.mem_addr, 0);
    check("t1 busy adv", bus.busy, 0);
    step();
    check("t1 inst_out", bus.inst_out, 8'hA5);
    check("t1 inst_valid", bus.inst_valid, 1);
    check("t1 busy idle", bus.busy, 1);
    check("t1 mem_req idle", bus.mem_req, 0);
    check("t1 pc", pc, 1);
    step();
    check("t1 next addr", bus.mem_addr, 1);
    check("t1 valid pulse", bus.inst_valid, 0);
    step();
    check("t1b inst_out", bus.inst_out, 8'h5A);
    check("t1b valid", bus.inst_valid, 1);

    // Ack delayed 5 cycles at addr 2
    wait_req("t2 req");
    for (int i = 0; i < 6; i++) begin
      check("t2 mem_req", bus.mem_req, 1);
      check("t2 mem_addr", bus.mem_addr, 2);
      check("t2 busy", bus.busy, (i == 5) ? 0 : 1);
      check("t2 no valid", bus.inst_valid, 0);
      step();
    end
    check("t2 inst_out", bus.inst_out, 8'h3C);
    check("t2 inst_valid", bus.inst_valid, 1);
    check("t2 pc", pc, 3);

    // Stall across the ack at addr 3
    bus.stall_in = 1'b1;
    step();
    check("t3 wait req", bus.mem_req, 1);
    check("t3 wait busy", bus.busy, 1);
    check("t3 inst held", bus.inst_out, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t3 hold req", bus.mem_req, 0);
      check("t3 hold busy", bus.busy, 1);
      check("t3 pc frozen", pc, 3);
      check("t3 hold valid", bus.inst_valid, 0);
    end
    bus.stall_in = 1'b0;
    #1;
    check("t3 release busy", bus.busy, 0);
    step();
    check("t3 inst_out", bus.inst_out, 8'h77);
    check("t3 inst_valid", bus.inst_valid, 1);
    check("t3 pc", pc, 4);

    // Jump to 9 while waiting at addr 4
    wait_req("t4 req");
    bus.jump_flag = 1'b1;
    jump_addr = 4'd9;
    check("t4 mem_addr", bus.mem_addr, 4);
    step();
    check("t4 no abort", bus.mem_req, 1);
    step();
    check("t4 busy adv", bus.busy, 0);
    step();
    check("t4 squashed", bus.inst_valid, 0);
    check("t4 inst_out", bus.inst_out, 8'h11);
    check("t4 pc jump", pc, 9);
    bus.jump_flag = 1'b0;
    step();
    check("t4 target addr", bus.mem_addr, 9);
    step();
    check("t4 next valid", bus.inst_valid, 1);
    check("t4 next inst", bus.inst_out, 8'hC3);

    // Reset mid-WAIT, stray ack after release
    wait_req("t5 req");
    check("t5 pre req", bus.mem_req, 1);
    check("t5 pre addr", bus.mem_addr, 10);
    rst = 1'b1;
    #1;
    check("t5 rst req", bus.mem_req, 0);
    check("t5 rst valid", bus.inst_valid, 0);
    check("t5 rst inst", bus.inst_out, 0);
    check("t5 rst busy", bus.busy, 1);
    step();
    rst = 1'b0;
    stray = 1'b1;
    #1;
    check("t5 stray busy", bus.busy, 1);
    check("t5 stray req", bus.mem_req, 0);
    #1;
    stray = 1'b0;
    step();
    check("t5 restart addr", bus.mem_addr, 0);
    check("t5 restart valid", bus.inst_valid, 0);
    step();
    check("t5 restart inst", bus.inst_out, 8'hA5);
    check("t5 restart vld", bus.inst_valid, 1);

`ifdef FETCH_TIMEOUT_EN
    // No ack at addr 1: timeout after 15 WAIT cycles, then retry
    delay_tab[1] = 20;
    wait_req("t6 req");
    for (int i = 0; i < 15; i++) begin
      check("t6 wait req", bus.mem_req, 1);
      check("t6 err clear", bus.fetch_err, 0);
      step();
    end
    check("t6 drop req", bus.mem_req, 0);
    check("t6 fetch_err", bus.fetch_err, 1);
    check("t6 no valid", bus.inst_valid, 0);
    check("t6 pc held", pc, 1);
    delay_tab[1] = 0;
    step();
    check("t6 retry req", bus.mem_req, 1);
    check("t6 retry addr", bus.mem_addr, 1);
    step();
    check("t6 retry inst", bus.inst_out, 8'h5A);
    check("t6 retry valid", bus.inst_valid, 1);
    check("t6 err sticky", bus.fetch_err, 1);
`else
    check("end fetch_err", bus.fetch_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
